// File: rtl/score_display_ctrl.sv
// Two-player score/game controller for the dot-matrix score display: edge-detected points,
// IDLE/PLAY/WIN sequencing and the row-scan tick. Define SCORE_FLASH_EN to flash the winner's digit.
module score_display_ctrl #(
    parameter int WIN_SCORE = 9,
    parameter int SCAN_DIV  = 1000,
    parameter int FLASH_DIV = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       point1,
    input  logic       point2,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] winner,
    output logic       playing,
    output logic       scan_en
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam logic [3:0] BLANK = 4'hF;

    if (WIN_SCORE < 1 || WIN_SCORE > 9) begin : g_bad_win
        $error("WIN_SCORE must be in 1..9");
    end
    if (SCAN_DIV < 2 || FLASH_DIV < 2) begin : g_bad_div
        $error("SCAN_DIV and FLASH_DIV must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, PLAY, WIN} state_t;

    state_t      state, state_n;
    logic [3:0]  s1, s2, s1_n, s2_n;
    logic [1:0]  winner_n;
    logic        start_q, point1_q, point2_q;
    logic        start_e, point1_e, point2_e;
    logic [3:0]  sum1, sum2;
    logic        hit1, hit2;
    logic        blank1, blank2;
    logic [SCAN_W-1:0] scan_cnt;

    assign start_e  = start  & ~start_q;
    assign point1_e = point1 & ~point1_q;
    assign point2_e = point2 & ~point2_q;
    assign sum1 = s1 + {3'b000, point1_e};
    assign sum2 = s2 + {3'b000, point2_e};
    assign hit1 = point1_e && (sum1 == 4'(WIN_SCORE));
    assign hit2 = point2_e && (sum2 == 4'(WIN_SCORE));

    // Start dominates everything; in PLAY both players can score in the same cycle.
    always_comb begin
        state_n  = state;
        s1_n     = s1;
        s2_n     = s2;
        winner_n = winner;
        if (start_e) begin
            state_n  = PLAY;
            s1_n     = 4'd0;
            s2_n     = 4'd0;
            winner_n = 2'b00;
        end else if (state == PLAY) begin
            s1_n = sum1;
            s2_n = sum2;
            if (hit1 || hit2) begin
                state_n  = WIN;
                winner_n = {hit2, hit1};
            end
        end
    end

`ifdef SCORE_FLASH_EN
    localparam int FLASH_W = $clog2(FLASH_DIV);
    logic [FLASH_W-1:0] flash_cnt, flash_cnt_n;
    logic               phase, phase_n;

    // Phase 0 is visible; the counter restarts on the cycle WIN is entered.
    always_comb begin
        flash_cnt_n = '0;
        phase_n     = 1'b0;
        if (state_n == WIN && state == WIN) begin
            if (flash_cnt == FLASH_W'(FLASH_DIV - 1)) begin
                phase_n = ~phase;
            end else begin
                flash_cnt_n = flash_cnt + FLASH_W'(1);
                phase_n     = phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            flash_cnt <= flash_cnt_n;
            phase     <= phase_n;
        end
    end

    assign blank1 = (state_n == WIN) && phase_n && winner_n[0];
    assign blank2 = (state_n == WIN) && phase_n && winner_n[1];
`else
    assign blank1 = 1'b0;
    assign blank2 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            s1       <= 4'd0;
            s2       <= 4'd0;
            score1   <= 4'd0;
            score2   <= 4'd0;
            winner   <= 2'b00;
            playing  <= 1'b0;
            start_q  <= 1'b0;
            point1_q <= 1'b0;
            point2_q <= 1'b0;
        end else begin
            state    <= state_n;
            s1       <= s1_n;
            s2       <= s2_n;
            score1   <= blank1 ? BLANK : s1_n;
            score2   <= blank2 ? BLANK : s2_n;
            winner   <= winner_n;
            playing  <= (state_n == PLAY);
            start_q  <= start;
            point1_q <= point1;
            point2_q <= point2;
        end
    end

    // Free-running scan divider; the tick is registered so it lands SCAN_DIV cycles after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            scan_en  <= 1'b0;
        end else begin
            scan_en  <= (scan_cnt == SCAN_W'(SCAN_DIV - 1));
            scan_cnt <= (scan_cnt == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_cnt + SCAN_W'(1);
        end
    end
endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl with WIN_SCORE=3, SCAN_DIV=4, FLASH_DIV=8.
module tb_score_display_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, point1 = 1'b0, point2 = 1'b0;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic       playing, scan_en;

    int n_vec = 0;
    int n_bad = 0;
    logic [10:0] exp_q[$];

    typedef struct packed {
        logic       st, p1, p2;
        logic [3:0] e1, e2;
        logic [1:0] w;
        logic       pl;
    } vec_t;
    vec_t vecs[$];

    score_display_ctrl #(.WIN_SCORE(3), .SCAN_DIV(4), .FLASH_DIV(8)) dut (
        .clk(clk), .rst(rst), .start(start), .point1(point1), .point2(point2),
        .score1(score1), .score2(score2), .winner(winner), .playing(playing), .scan_en(scan_en)
    );

    always #5 clk = ~clk;

    task automatic add(input logic st, p1, p2, input logic [3:0] e1, e2,
                       input logic [1:0] w, input logic pl);
        vecs.push_back('{st, p1, p2, e1, e2, w, pl});
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Called at posedge+1: drive inputs, queue the expectation, compare after the next edge.
    task automatic apply(input string name, input logic st, p1, p2, input logic [3:0] e1, e2,
                         input logic [1:0] w, input logic pl);
        logic [10:0] exp_v, got_v;
        start = st; point1 = p1; point2 = p2;
        exp_q.push_back({e1, e2, w, pl});
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        got_v = {score1, score2, winner, playing};
        n_vec++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got s1=%h s2=%h w=%b pl=%b want s1=%h s2=%h w=%b pl=%b", name,
                     got_v[10:7], got_v[6:3], got_v[2:1], got_v[0],
                     exp_v[10:7], exp_v[6:3], exp_v[2:1], exp_v[0]);
        end
    endtask

    initial begin
        logic [3:0] d;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        apply("reset_hold", 0, 0, 0, 0, 0, 2'b00, 0);
        check_bit("reset_scan_en", scan_en, 1'b0);
        rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check_bit($sformatf("scan_tick_c%0d", k), scan_en, (k % 4) == 0);
            check_bit($sformatf("idle_playing_c%0d", k), playing, 1'b0);
        end

        // Main game sequence: {start, p1, p2} -> {score1, score2, winner, playing}
        add(0,1,0, 0,0,2'b00,0);  // point in IDLE ignored
        add(0,0,0, 0,0,2'b00,0);
        add(1,0,0, 0,0,2'b00,1);  // start
        add(0,0,0, 0,0,2'b00,1);
        add(0,1,0, 1,0,2'b00,1);  // point1 held 5 cycles counts once
        add(0,1,0, 1,0,2'b00,1);
        add(0,1,0, 1,0,2'b00,1);
        add(0,1,0, 1,0,2'b00,1);
        add(0,1,0, 1,0,2'b00,1);
        add(0,0,0, 1,0,2'b00,1);
        add(0,1,0, 2,0,2'b00,1);
        add(0,0,0, 2,0,2'b00,1);
        add(0,0,1, 2,1,2'b00,1);
        add(0,0,0, 2,1,2'b00,1);
        add(1,0,1, 0,0,2'b00,1);  // restart beats same-cycle point2
        add(0,0,0, 0,0,2'b00,1);
        add(0,1,0, 1,0,2'b00,1);
        add(0,0,0, 1,0,2'b00,1);
        add(0,1,0, 2,0,2'b00,1);
        add(0,0,0, 2,0,2'b00,1);
        add(0,0,1, 2,1,2'b00,1);
        add(0,0,0, 2,1,2'b00,1);
        add(0,1,1, 3,2,2'b01,0);  // player 1 wins, simultaneous increment
        add(0,0,0, 3,2,2'b01,0);
        add(0,1,0, 3,2,2'b01,0);  // points ignored in WIN (still in visible phase)
        add(0,0,0, 3,2,2'b01,0);
        add(0,0,1, 3,2,2'b01,0);
        add(0,0,0, 3,2,2'b01,0);
        add(1,0,0, 0,0,2'b00,1);  // restart from WIN
        add(0,0,0, 0,0,2'b00,1);
        add(0,1,1, 1,1,2'b00,1);
        add(0,0,0, 1,1,2'b00,1);
        add(0,1,1, 2,2,2'b00,1);
        add(0,0,0, 2,2,2'b00,1);
        add(0,1,1, 3,3,2'b11,0);  // draw
        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].st, vecs[i].p1, vecs[i].p2,
                  vecs[i].e1, vecs[i].e2, vecs[i].w, vecs[i].pl);

        // Draw flash: entry cycle + 7 visible, then 8 blank, then visible again
        for (int i = 1; i <= 17; i++) begin
            d = 4'd3;
`ifdef SCORE_FLASH_EN
            if (i >= 8 && i < 16) d = 4'hF;
`endif
            apply($sformatf("draw_flash%0d", i), 0, 0, 0, d, d, 2'b11, 0);
        end

        // Asynchronous reset mid-game at 2/0
        apply("rs_start", 1, 0, 0, 0, 0, 2'b00, 1);
        apply("rs_a", 0, 1, 0, 1, 0, 2'b00, 1);
        apply("rs_b", 0, 0, 0, 1, 0, 2'b00, 1);
        apply("rs_c", 0, 1, 0, 2, 0, 2'b00, 1);
        apply("rs_d", 0, 0, 0, 2, 0, 2'b00, 1);
        #3 rst = 1'b0;
        #1;
        check_bit("async_rst_s1", score1 == 4'd0, 1'b1);
        check_bit("async_rst_s2", score2 == 4'd0, 1'b1);
        check_bit("async_rst_winner", winner == 2'b00, 1'b1);
        check_bit("async_rst_playing", playing, 1'b0);
        check_bit("async_rst_scan_en", scan_en, 1'b0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        apply("post_rst_p1", 0, 1, 0, 0, 0, 2'b00, 0);
        apply("post_rst_idle", 0, 0, 0, 0, 0, 2'b00, 0);
        apply("post_rst_start", 1, 0, 0, 0, 0, 2'b00, 1);
        apply("post_rst_p2", 0, 0, 1, 0, 1, 2'b00, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Game/score controller that sequences the two-digit dot-matrix score display.
- Edge-detects the player point inputs and keeps two decimal scores.
- Runs the IDLE/PLAY/WIN game FSM and, when built with the optional feature, flashes the winner's digit by driving the blank code.
- Generates the row-scan enable tick for the matrix driver. score1/score2 connect directly to the matrix driver's score inputs; scan_en gates the driver's row-advance.

Parameters:
- WIN_SCORE, 9, score that ends the game; legal range 1..9.
- SCAN_DIV, 1000, clk cycles per row-scan tick; must be ≥2.
- FLASH_DIV, 250000, clk cycles per flash half-period; must be ≥2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- start  input  1  synchronous level; rising edge starts or restarts a game
- point1  input  1  synchronous level; rising edge awards player 1 a point
- point2  input  1  synchronous level; rising edge awards player 2 a point
- score1  output  4  digit to matrix column set 1 (0..9, or 4'hF = blank)
- score2  output  4  digit to matrix column set 2 (0..9, or 4'hF = blank)
- winner  output  2  00 none, 01 player1, 10 player2, 11 draw
- playing  output  1  high in PLAY state
- scan_en  output  1  one-cycle row-scan tick

Behaviour:

Reset and edge detection:
- Reset is asynchronous, active-low on rst; clock is clk. Reset takes effect immediately, including mid-game.
- Reset values: state IDLE; s1=s2=0; score1=score2=0; winner=00; playing=0; scan_en=0; scan and flash counters 0; edge-detect history registers 0.
- Edge detect on start/point1/point2: input high while its registered previous value is low. A level held high counts once.

Registered outputs and timing:
- All outputs are registered.
- A score change is visible on score1/score2 on the clock edge that samples the rising edge of point1/point2 (1-cycle latency from first high sample).

FSM states:
- IDLE: scores shown as 0/0; point edges ignored. Start edge -> PLAY with s1=s2=0, winner=00.
- PLAY: playing=1.
  - point1 edge: s1 <= s1+1. point2 edge: s2 <= s2+1.
  - Simultaneous edges: both increment in the same cycle.
  - If a new value equals WIN_SCORE, go to WIN in that same edge. winner = 01, 10, or 11 if both reach WIN_SCORE together.
  - Start edge in PLAY: restart, clearing scores to 0/0 and staying in PLAY. Start takes priority over same-cycle point edges.
- WIN: playing=0; point edges ignored; scores frozen; winner held. Start edge -> PLAY with scores cleared and winner=00.

Arithmetic:
- Scores are 4-bit and never exceed WIN_SCORE; no wrap is possible because the game ends on reaching WIN_SCORE.

Scan tick:
- Free-running counter 0..SCAN_DIV-1, independent of state.
- scan_en=1 for exactly the cycle the counter equals SCAN_DIV-1, then the counter wraps to 0.
- First tick occurs SCAN_DIV cycles after reset release.

Flash counter:
- Counts 0..FLASH_DIV-1 only in WIN and toggles a phase bit on wrap.
- Cleared to 0, with phase = visible, on entry to WIN.

Optional Feature:
- Macro: SCORE_FLASH_EN.
- Defined: in WIN, the winning player's digit alternates between its value (visible phase) and 4'hF (blank phase) every FLASH_DIV cycles, starting visible on the WIN entry cycle. The loser's digit stays steady; on a draw both digits flash in phase. Leaving WIN restores steady display on the next edge.
- Undefined: no flash counter is built; WIN shows both scores steadily and 4'hF never appears on score outputs.

Test Plan (WIN_SCORE=3, SCAN_DIV=4, FLASH_DIV=8):
- Release reset, idle 12 cycles -> scan_en high on cycles 4, 8, 12 only (one cycle each); score1=score2=0, winner=00, playing=0.
- Pulse point1 in IDLE, then start, then hold point1 high 5 cycles -> IDLE point ignored; after start playing=1, scores 0/0; held point1 yields score1=1 only, 1 cycle after first high sample.
- In PLAY at 2/1, assert point1 and point2 in the same cycle -> next edge score1=3, score2=2, winner=01, playing=0; further point pulses leave scores unchanged.
- From 2/2, assert simultaneous point edges -> 3/3, winner=11; with SCORE_FLASH_EN both digits read 3 for 8 cycles, 4'hF for 8, 3 again; without the macro both read a steady 3.
- At 2/1 in PLAY, assert start together with point2 -> scores 0/0, winner=00, playing stays 1 (restart wins).
- At 2/0 in PLAY, drive rst low asynchronously between clock edges -> all outputs return to reset values immediately; after release, start is required to resume play.
